// File: rtl/csnn_seq_ctrl.sv
// Top-level sequencer for the CSNN pipeline. It drives the shared system_state bus,
// paces timesteps, clears potentials at inference start and hands off to the UART.
module csnn_seq_ctrl #(
    parameter int unsigned T_STEPS     = 16,
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         frame_valid,
    input  logic                         uart_busy,
    input  logic                         uart_done,
    output logic [1:0]                   system_state,
    output logic                         clear_pot,
    output logic                         step_en,
    output logic [$clog2(T_STEPS+1)-1:0] step_idx,
    output logic                         uart_start,
    output logic                         done
);

    localparam int unsigned IW = $clog2(T_STEPS + 1);
    localparam int unsigned CW = $clog2(STEP_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [IW-1:0] LAST_STEP = IW'(T_STEPS - 1);
    localparam logic [CW-1:0] LAST_CYC  = CW'(STEP_CYCLES - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SAMPLE   = 2'b01,
        UART     = 2'b11,
        COMPLETE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          launched_q, launched_d;
    logic          clear_pot_d, step_en_d, uart_start_d, done_d;
    logic [IW-1:0] step_idx_d;

    assign system_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            hold_q     <= '0;
            launched_q <= 1'b0;
            clear_pot  <= 1'b0;
            step_en    <= 1'b0;
            step_idx   <= '0;
            uart_start <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            hold_q     <= hold_d;
            launched_q <= launched_d;
            clear_pot  <= clear_pot_d;
            step_en    <= step_en_d;
            step_idx   <= step_idx_d;
            uart_start <= uart_start_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        hold_d       = hold_q;
        launched_d   = launched_q;
        step_idx_d   = step_idx;
        clear_pot_d  = 1'b0;
        step_en_d    = 1'b0;
        uart_start_d = 1'b0;
        done_d       = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            cyc_d      = '0;
            hold_d     = '0;
            launched_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = SAMPLE;
                        clear_pot_d = 1'b1;
                        step_idx_d  = '0;
                        cyc_d       = '0;
                    end
                end
                SAMPLE: begin
                    if (frame_valid) begin
                        if (cyc_q == LAST_CYC) begin
                            cyc_d      = '0;
                            step_en_d  = 1'b1;
                            step_idx_d = step_idx + 1'b1;
                            if (step_idx == LAST_STEP) state_d = UART;
                        end else begin
                            cyc_d = cyc_q + 1'b1;
                        end
                    end
                end
                UART: begin
                    // uart_done is only trusted once the launch pulse has already been seen
                    if (!launched_q && !uart_busy) begin
                        uart_start_d = 1'b1;
                        launched_d   = 1'b1;
                    end else if (launched_q && !uart_start && uart_done) begin
                        state_d    = COMPLETE;
                        launched_d = 1'b0;
                        done_d     = 1'b1;
                        hold_d     = '0;
                    end
                end
                COMPLETE: begin
                    if (hold_q == LAST_HOLD) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csnn_seq_ctrl.sv
// Scoreboard bench for csnn_seq_ctrl: expected per-cycle outputs are derived from the
// event timeline of each scenario and compared cycle by cycle.
module tb_csnn_seq_ctrl;

    localparam int HC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, frame_valid = 1'b0;
    logic       uart_busy = 1'b0, uart_done = 1'b0;
    logic [1:0] system_state;
    logic       clear_pot, step_en, uart_start, done;
    logic [2:0] step_idx;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] st;
        logic       clr;
        logic       sen;
        logic [2:0] idx;
        logic       us;
        logic       dn;
    } obs_t;

    // Event cycles of one scenario; abort_at < 0 means no abort, restart == 0 means none.
    typedef struct {
        int clr;
        int s0, s1, s2, s3;
        int uin;
        int ust;
        int comp;
        int abort_at;
        int restart;
    } plan_t;

    obs_t sb[$];

    always #5 clk = ~clk;

    csnn_seq_ctrl #(.T_STEPS(4), .STEP_CYCLES(2), .HOLD_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .frame_valid(frame_valid), .uart_busy(uart_busy), .uart_done(uart_done),
        .system_state(system_state), .clear_pot(clear_pot), .step_en(step_en),
        .step_idx(step_idx), .uart_start(uart_start), .done(done)
    );

    function automatic obs_t exp_at(plan_t p, int c);
        obs_t e;
        int   n;
        e = '0;
        n = 0;
        if (p.restart > 0 && c >= p.restart) begin
            e.st  = 2'b01;
            e.clr = (c == p.restart);
            return e;
        end
        if (c < p.clr) return e;
        if (p.s0 <= c && (p.abort_at < 0 || p.s0 <= p.abort_at)) n++;
        if (p.s1 <= c && (p.abort_at < 0 || p.s1 <= p.abort_at)) n++;
        if (p.s2 <= c && (p.abort_at < 0 || p.s2 <= p.abort_at)) n++;
        if (p.s3 <= c && (p.abort_at < 0 || p.s3 <= p.abort_at)) n++;
        e.idx = 3'(n);
        if (p.abort_at >= 0 && c > p.abort_at) return e;
        e.clr = (c == p.clr);
        e.sen = (c == p.s0 || c == p.s1 || c == p.s2 || c == p.s3);
        e.us  = (c == p.ust);
        e.dn  = (c == p.comp);
        if (c < p.uin)            e.st = 2'b01;
        else if (c < p.comp)      e.st = 2'b11;
        else if (c < p.comp + HC) e.st = 2'b10;
        else                      e.st = 2'b00;
        return e;
    endfunction

    task automatic do_reset();
        start = 0; abort = 0; frame_valid = 0; uart_busy = 0; uart_done = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        plan_t p = '{clr:1, s0:3, s1:5, s2:7, s3:9, uin:9, ust:10, comp:16, abort_at:-1, restart:0};
        obs_t  e, o;
        do_reset();
        o = {system_state, clear_pot, step_en, step_idx, uart_start, done};
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", o, 9'b0);
        end
        for (int c = 0; c <= 4; c++) begin
            start = (c == 0); frame_valid = 1; uart_busy = 0; uart_done = 0; abort = 0;
            sb.push_back(exp_at(p, c));
            @(posedge clk); #1;
        end
        // Mid-cycle 5 of SAMPLE: reset must act without a clock edge.
        #2 rst = 1;
        #1;
        o = {system_state, clear_pot, step_en, step_idx, uart_start, done};
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", o, 9'b0);
        end
        sb.delete();
        #1 rst = 0;
        @(posedge clk); #1;
        for (int c = 0; c <= 3; c++) begin
            start = (c == 0); frame_valid = 1;
            sb.push_back(exp_at(p, c));
            e = sb.pop_front();
            o = {system_state, clear_pot, step_en, step_idx, uart_start, done};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL restart_after_reset c=%0d got=%b want=%b", c, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nominal();
        plan_t p = '{clr:1, s0:3, s1:5, s2:7, s3:9, uin:9, ust:10, comp:16, abort_at:-1, restart:0};
        obs_t  e, o;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            start = (c == 0); frame_valid = 1; uart_busy = 0; uart_done = (c == 15); abort = 0;
            sb.push_back(exp_at(p, c));
            e = sb.pop_front();
            o = {system_state, clear_pot, step_en, step_idx, uart_start, done};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL nominal c=%0d got=%b want=%b", c, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        plan_t p = '{clr:1, s0:6, s1:8, s2:10, s3:12, uin:12, ust:13, comp:19, abort_at:-1, restart:0};
        obs_t  e, o;
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            start = (c == 0); frame_valid = !(c >= 2 && c <= 4);
            uart_busy = 0; uart_done = (c == 18); abort = 0;
            sb.push_back(exp_at(p, c));
            e = sb.pop_front();
            o = {system_state, clear_pot, step_en, step_idx, uart_start, done};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall c=%0d got=%b want=%b", c, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_uart();
        plan_t p = '{clr:1, s0:3, s1:5, s2:7, s3:9, uin:9, ust:15, comp:18, abort_at:-1, restart:0};
        obs_t  e, o;
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            start = (c == 0); frame_valid = 1; uart_busy = (c <= 13);
            uart_done = (c == 12 || c == 15 || c == 17); abort = 0;
            sb.push_back(exp_at(p, c));
            e = sb.pop_front();
            o = {system_state, clear_pot, step_en, step_idx, uart_start, done};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL busy_uart c=%0d got=%b want=%b", c, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        plan_t p = '{clr:1, s0:3, s1:5, s2:7, s3:9, uin:9, ust:10, comp:16, abort_at:6, restart:9};
        obs_t  e, o;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            start = (c == 0 || c == 7 || c == 8); frame_valid = 1; uart_busy = 0;
            uart_done = 0; abort = (c == 6 || c == 7);
            sb.push_back(exp_at(p, c));
            e = sb.pop_front();
            o = {system_state, clear_pot, step_en, step_idx, uart_start, done};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL abort c=%0d got=%b want=%b", c, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_spurious_start();
        plan_t p = '{clr:1, s0:3, s1:5, s2:7, s3:9, uin:9, ust:10, comp:16, abort_at:-1, restart:20};
        obs_t  e, o;
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            start = 1; frame_valid = 1; uart_busy = 0; uart_done = (c == 15); abort = 0;
            sb.push_back(exp_at(p, c));
            e = sb.pop_front();
            o = {system_state, clear_pot, step_en, step_idx, uart_start, done};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL spurious_start c=%0d got=%b want=%b", c, o, e);
            end
            @(posedge clk); #1;
        end
        start = 0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_busy_uart();
        test_abort();
        test_spurious_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csnn_seq_ctrl.md
# csnn_seq_ctrl

Top-level sequencer for the CSNN classification pipeline. It generates the shared `system_state` bus (IDLE/SAMPLE/UART/COMPLETE) that the output-decode, neuron and UART blocks consume. It paces the timesteps of one inference, clears membrane potentials at the start of each inference, and launches and awaits the UART result transfer. It holds COMPLETE long enough for the decode stage to latch the classification, then returns to IDLE.

## Interface
- `T_STEPS`, 16: timesteps per inference; must be ≥ 1.
- `STEP_CYCLES`, 4: enabled clock cycles per timestep; must be ≥ 1.
- `HOLD_CYCLES`, 8: cycles spent in COMPLETE; must be ≥ 1.
- `clk`, in, 1: the single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: starts an inference; sampled only in IDLE.
- `abort`, in, 1: synchronous abort; takes priority over every other input.
- `frame_valid`, in, 1: input spikes are valid this cycle; low stalls timestep pacing.
- `uart_busy`, in, 1: UART transmitter is occupied.
- `uart_done`, in, 1: one-cycle pulse when the UART transfer finishes.
- `system_state`, out, 2: IDLE=2'b00, SAMPLE=2'b01, UART=2'b11, COMPLETE=2'b10.
- `clear_pot`, out, 1: one-cycle pulse that zeroes all membrane potentials.
- `step_en`, out, 1: one-cycle pulse that advances the neuron array by one timestep.
- `step_idx`, out, $clog2(T_STEPS+1): count of completed timesteps.
- `uart_start`, out, 1: one-cycle pulse that launches the result transfer.
- `done`, out, 1: one-cycle pulse on entry to COMPLETE.

## Operation
- Every output is registered. Reset values: `system_state`=IDLE and all other outputs 0. Internal cycle counter, hold counter and launched flag also reset to 0.
- IDLE: when `start` is high, go to SAMPLE next edge. On that edge set `clear_pot`=1 for one cycle and set `step_idx`=0 and the cycle counter `cyc`=0.
- SAMPLE: `cyc` increments only on cycles with `frame_valid`=1. When `cyc`=STEP_CYCLES-1 and `frame_valid`=1:
  - `cyc` wraps to 0;
  - next cycle `step_en`=1;
  - `step_idx` increments.
- When that wrap completes step T_STEPS, the same edge moves the state to UART. The final `step_en` pulse therefore coincides with the first UART cycle. Datapath blocks honor `step_en` regardless of state.
- UART: while the launched flag is 0 and `uart_busy`=0, pulse `uart_start` on the next cycle and set the flag. While `uart_busy`=1, launch is deferred indefinitely.
  - `uart_done` is ignored until the cycle after `uart_start`.
  - Once accepted, `uart_done` moves the state to COMPLETE next edge and clears the flag.
- COMPLETE: `done`=1 in the first cycle. Hold for HOLD_CYCLES cycles, then go to IDLE. `step_idx` keeps its final value T_STEPS until the next start.
- `start` outside IDLE is ignored and is not queued.
- `abort`=1 in any state: next edge forces IDLE and clears `cyc`, the hold counter and the launched flag. All pulse outputs are 0 on that edge, no `done` is issued, and `step_idx` is held. `abort` and `start` high together in IDLE gives IDLE.
- Reset asserted mid-inference returns everything to reset values immediately, asynchronously.

## Timing
- Cycle 0 is the edge that samples `start`. SAMPLE occupies cycles 1..T_STEPS·STEP_CYCLES when `frame_valid` stays high. Each low cycle of `frame_valid` adds one cycle.
- With no stalls, `step_en` pulses in cycles STEP_CYCLES·k+1 for k=1..T_STEPS.
- First UART cycle is T_STEPS·STEP_CYCLES+1. `uart_start` arrives 1 cycle later if `uart_busy` is low.
- Latency from `uart_done` to `system_state`=COMPLETE is 1 cycle. Latency from the last COMPLETE cycle to IDLE is 1 cycle.
- Minimum cycles from IDLE back to IDLE: T_STEPS·STEP_CYCLES + 2 + (UART turnaround) + HOLD_CYCLES.

## Test plan
All scenarios use T_STEPS=4, STEP_CYCLES=2, HOLD_CYCLES=3.
- **Reset:** assert `rst` mid-SAMPLE, without a clock edge -> `system_state`=00 and every output 0 immediately. After release, a `start` begins cleanly.
- **Nominal run:** `start` at cycle 0 with `frame_valid`=1 and `uart_done` at cycle 15 ->
  - `clear_pot` in cycle 1;
  - `step_en` in cycles 3,5,7,9;
  - UART from cycle 9, `uart_start` in cycle 10;
  - COMPLETE and `done` in cycle 16, COMPLETE through cycle 18;
  - IDLE in cycle 19, `step_idx`=4.
- **Stall:** drop `frame_valid` for cycles 2-4 of the nominal run -> `step_en` moves to cycles 6,8,10,12 and UART is entered at cycle 12.
- **Busy UART:** `uart_busy`=1 until cycle 14 -> `uart_start` in cycle 15. A `uart_done` driven at cycle 12 is ignored.
- **Abort:** `abort` at cycle 6 -> IDLE at cycle 7, no `done`, `step_idx`=2. `start` at cycle 8 restarts with `clear_pot` in cycle 9.
- **Spurious start:** `start` held high throughout a run -> exactly one new inference begins the cycle after COMPLETE exits. No extra `clear_pot` occurs mid-run.
